// File: rtl/window_generator.sv
// Raster-scan KxK window generator: K-1 line buffers feeding a KxK window register.
// Optional WINDOW_COUNT_EN adds a saturating window_count output.
module window_generator #(
  parameter int DATA_WIDTH  = 16,
  parameter int KERNEL_SIZE = 5,
  parameter int IMG_WIDTH   = 28,
  parameter int IMG_HEIGHT  = 28
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic in_valid,
  output logic in_ready,
  input  logic [DATA_WIDTH-1:0] pixel_in,
  output logic win_valid,
  input  logic win_ready,
  output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] pixel_data,
`ifdef WINDOW_COUNT_EN
  output logic [15:0] window_count,
`endif
  output logic frame_done
);

  localparam int K  = KERNEL_SIZE;
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(K - 1);
  localparam logic [RW-1:0] ROW_MIN  = RW'(K - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;

  logic [DATA_WIDTH-1:0] line_buf [K-1][IMG_WIDTH];
  logic [DATA_WIDTH-1:0] win [K][K];
  logic [DATA_WIDTH-1:0] new_col [K];

  logic accept;
  logic emit;
  logic col_end;
  logic row_end;

  assign in_ready = (!win_valid || win_ready) && !clear;
  assign accept   = in_valid && in_ready;
  assign emit     = (row >= ROW_MIN) && (col >= COL_MIN);
  assign col_end  = (col == COL_LAST);
  assign row_end  = (row == ROW_LAST);

  always_comb begin
    for (int r = 0; r < K-1; r++) begin
      new_col[r] = line_buf[r][col];
    end
    new_col[K-1] = pixel_in;
  end

  // Line buffers are pure storage; rows < K-1 are never emitted, so no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int j = 0; j < K-2; j++) begin
        line_buf[j][col] <= line_buf[j+1][col];
      end
      line_buf[K-2][col] <= pixel_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col        <= '0;
      row        <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          win[r][c] <= '0;
        end
      end
    end else begin
      frame_done <= 1'b0;
      if (accept) begin
        for (int r = 0; r < K; r++) begin
          for (int c = 0; c < K-1; c++) begin
            win[r][c] <= win[r][c+1];
          end
          win[r][K-1] <= new_col[r];
        end
      end
      if (clear) begin
        col       <= '0;
        row       <= '0;
        win_valid <= 1'b0;
      end else begin
        if (accept && emit) begin
          win_valid <= 1'b1;
        end else if (win_ready) begin
          win_valid <= 1'b0;
        end
        if (accept) begin
          frame_done <= col_end && row_end;
          if (col_end) begin
            col <= '0;
            row <= row_end ? '0 : row + RW'(1);
          end else begin
            col <= col + CW'(1);
          end
        end
      end
    end
  end

  for (genvar r = 0; r < K; r++) begin : g_row
    for (genvar c = 0; c < K; c++) begin : g_col
      assign pixel_data[(r*K+c)*DATA_WIDTH +: DATA_WIDTH] = win[r][c];
    end
  end

`ifdef WINDOW_COUNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      window_count <= '0;
    end else if (clear) begin
      window_count <= '0;
    end else if (win_valid && win_ready && window_count != 16'hFFFF) begin
      window_count <= window_count + 16'd1;
    end
  end
`endif

endmodule
